// File: rtl/alu_pkg.sv
// Shared ALU types for the serial add/sub unit.
//   alu_op_t       : run-time operation select (add / subtract).
//   addsub_state_t : control FSM states.
//   FLAG_*         : bit positions of the NZCV flags in the packed flag register.
package alu_pkg;

   typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} alu_op_t;

   typedef enum logic {S_IDLE, S_RUN} addsub_state_t;

   localparam int NUM_FLAGS = 4;
   localparam int FLAG_N    = 3;
   localparam int FLAG_Z    = 2;
   localparam int FLAG_C    = 1;
   localparam int FLAG_V    = 0;

endpackage

// File: rtl/serial_addsub_if.sv
// Request/response bundle for serial_addsub.
//   Request  (master -> slave): start, op, a, b, cin
//   Response (slave -> master): busy, done, r, cout, N, Z, C, V
interface serial_addsub_if import alu_pkg::*; #(
   parameter int WIDTH = 8
);
   logic             start;
   alu_op_t          op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] r;
   logic             cout;
   logic             N;
   logic             Z;
   logic             C;
   logic             V;

   modport master (output start, op, a, b, cin,
                   input  busy, done, r, cout, N, Z, C, V);

   modport slave  (input  start, op, a, b, cin,
                   output busy, done, r, cout, N, Z, C, V);
endinterface

// File: rtl/serial_addsub_digit.sv
// addsub_digit: combinational DIGIT-bit ripple of add/subtract cells.
//   x, y  : DIGIT-bit operand slices
//   c_in  : carry-in (add) or borrow-in (sub)
//   op    : OP_ADD / OP_SUB
//   s     : DIGIT-bit sum/difference slice
//   c_out : carry-out (add) or borrow-out (sub)
// Subtraction reuses the adder cell: a - b - borrow == a + ~b + ~borrow, so the
// chain runs in the carry domain with y and the borrow ends inverted.
module addsub_digit import alu_pkg::*; #(
   parameter int DIGIT = 1
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic             c_in,
   input  alu_op_t          op,
   output logic [DIGIT-1:0] s,
   output logic             c_out
);
   logic             inv;
   logic [DIGIT:0]   cy;

   assign inv   = (op == OP_SUB);
   assign cy[0] = c_in ^ inv;

   for (genvar i = 0; i < DIGIT; i++) begin : g_cell
      logic yi;
      assign yi      = y[i] ^ inv;
      assign s[i]    = x[i] ^ yi ^ cy[i];
      assign cy[i+1] = (x[i] & yi) | (x[i] & cy[i]) | (yi & cy[i]);
   end

   assign c_out = cy[DIGIT] ^ inv;
endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: multi-cycle add/subtract, DIGIT bits per clock, LSB first.
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   bus      : request (start, op, a, b, cin) / response (busy, done, r, cout,
//              N, Z, C, V); r, cout and flags are registered and only change
//              at reset or on the edge that raises done.
module serial_addsub import alu_pkg::*; #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic            clk,
   input  logic            rst,
   serial_addsub_if.slave  bus
);
   localparam int STEPS = WIDTH / DIGIT;
   localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

   if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_param
      $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
   end

   addsub_state_t          state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0]       a_sh_q, a_sh_d, b_sh_q, b_sh_d, res_sh_q, res_sh_d;
   alu_op_t                op_q, op_d;
   logic                   cy_q, cy_d;
   logic                   a_msb_q, a_msb_d, b_msb_q, b_msb_d;
   logic [WIDTH-1:0]       r_q, r_d;
   logic                   cout_q, cout_d;
   logic [NUM_FLAGS-1:0]   flags_q, flags_d;
   logic                   done_q, done_d;

   logic [DIGIT-1:0]       dig_s;
   logic                   dig_c;
   logic [WIDTH+DIGIT-1:0] res_cat;
   logic [WIDTH-1:0]       res_next;
   logic                   r_msb;

   addsub_digit #(.DIGIT(DIGIT)) u_digit (
      .x     (a_sh_q[DIGIT-1:0]),
      .y     (b_sh_q[DIGIT-1:0]),
      .c_in  (cy_q),
      .op    (op_q),
      .s     (dig_s),
      .c_out (dig_c)
   );

   // New result digits enter at the top; after STEPS shifts the LSB digit
   // has reached bit 0. Concatenation keeps this valid when DIGIT == WIDTH.
   assign res_cat  = {dig_s, res_sh_q};
   assign res_next = res_cat[WIDTH+DIGIT-1:DIGIT];
   assign r_msb    = res_next[WIDTH-1];

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      res_sh_d = res_sh_q;
      op_d     = op_q;
      cy_d     = cy_q;
      a_msb_d  = a_msb_q;
      b_msb_d  = b_msb_q;
      r_d      = r_q;
      cout_d   = cout_q;
      flags_d  = flags_q;
      done_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               a_sh_d   = bus.a;
               b_sh_d   = bus.b;
               op_d     = bus.op;
               cy_d     = bus.cin;
               a_msb_d  = bus.a[WIDTH-1];
               b_msb_d  = bus.b[WIDTH-1];
               res_sh_d = '0;
               cnt_d    = '0;
               state_d  = S_RUN;
            end
         end
         S_RUN: begin
            a_sh_d   = a_sh_q >> DIGIT;
            b_sh_d   = b_sh_q >> DIGIT;
            res_sh_d = res_next;
            cy_d     = dig_c;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(STEPS - 1)) begin
               state_d         = S_IDLE;
               cnt_d           = '0;
               done_d          = 1'b1;
               r_d             = res_next;
               cout_d          = dig_c;
               flags_d[FLAG_N] = r_msb;
               flags_d[FLAG_Z] = (res_next == '0);
               flags_d[FLAG_C] = dig_c;
               // Overflow from captured operand signs, not live inputs.
               if (op_q == OP_SUB)
                  flags_d[FLAG_V] = (a_msb_q != b_msb_q) && (r_msb != a_msb_q);
               else
                  flags_d[FLAG_V] = (a_msb_q == b_msb_q) && (r_msb != a_msb_q);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         res_sh_q <= '0;
         op_q     <= OP_ADD;
         cy_q     <= 1'b0;
         a_msb_q  <= 1'b0;
         b_msb_q  <= 1'b0;
         r_q      <= '0;
         cout_q   <= 1'b0;
         flags_q  <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         res_sh_q <= res_sh_d;
         op_q     <= op_d;
         cy_q     <= cy_d;
         a_msb_q  <= a_msb_d;
         b_msb_q  <= b_msb_d;
         r_q      <= r_d;
         cout_q   <= cout_d;
         flags_q  <= flags_d;
         done_q   <= done_d;
      end
   end

   assign bus.busy = (state_q == S_RUN);
   assign bus.done = done_q;
   assign bus.r    = r_q;
   assign bus.cout = cout_q;
   assign bus.N    = flags_q[FLAG_N];
   assign bus.Z    = flags_q[FLAG_Z];
   assign bus.C    = flags_q[FLAG_C];
   assign bus.V    = flags_q[FLAG_V];
endmodule
